// File: rtl/register_file_arbiter.sv
// register_file_arbiter: round-robin valid/ready sharing of one register_file write port and read port a, with a zeroing sweep after reset
//   clk, reset                      : clock, synchronous active-high reset
//   reqN_valid/write/index/wdata    : requester N transaction (N=0,1)
//   reqN_ready                      : requester N granted this cycle
//   respN_valid/respN_rdata         : 1-cycle read response pulse / held read data
//   rf_read_index_a, rf_read_data_a : register_file read port a (combinational read)
//   rf_write_index/data/enable      : register_file write port
module register_file_arbiter #(
  parameter int DATA_WIDTH  = 16,
  parameter int INDEX_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic                   req0_write,
  input  logic [INDEX_WIDTH-1:0] req0_index,
  input  logic [DATA_WIDTH-1:0]  req0_wdata,
  output logic                   resp0_valid,
  output logic [DATA_WIDTH-1:0]  resp0_rdata,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic                   req1_write,
  input  logic [INDEX_WIDTH-1:0] req1_index,
  input  logic [DATA_WIDTH-1:0]  req1_wdata,
  output logic                   resp1_valid,
  output logic [DATA_WIDTH-1:0]  resp1_rdata,
  output logic [INDEX_WIDTH-1:0] rf_read_index_a,
  input  logic [DATA_WIDTH-1:0]  rf_read_data_a,
  output logic [INDEX_WIDTH-1:0] rf_write_index,
  output logic [DATA_WIDTH-1:0]  rf_write_data,
  output logic                   rf_write_enable
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, next_state;
  logic [INDEX_WIDTH-1:0] cnt;
  logic rr, g0, g1, gw;
  logic [INDEX_WIDTH-1:0] g_index;
  logic [DATA_WIDTH-1:0] g_wdata;
  always_comb begin
    next_state = state;
    g0 = 1'b0;
    g1 = 1'b0;
    if (state == INIT) next_state = (cnt == {INDEX_WIDTH{1'b1}}) ? RUN : INIT;
    if (state == RUN && !reset) begin
      g0 = req0_valid && (!req1_valid || !rr);
      g1 = req1_valid && (!req0_valid || rr);
    end
    gw = g0 ? req0_write : req1_write;
    g_index = g0 ? req0_index : req1_index;
    g_wdata = g0 ? req0_wdata : req1_wdata;
  end
  assign req0_ready = g0;
  assign req1_ready = g1;
  assign rf_write_enable = !reset && (state == INIT || ((g0 || g1) && gw));
  assign rf_write_index = reset ? '0 : state == INIT ? cnt : ((g0 || g1) && gw) ? g_index : '0;
  assign rf_write_data = ((g0 || g1) && gw) ? g_wdata : '0;
  assign rf_read_index_a = ((g0 || g1) && !gw) ? g_index : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      cnt <= '0;
      rr <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp0_rdata <= '0;
      resp1_rdata <= '0;
    end else begin
      state <= next_state;
      if (state == INIT) cnt <= cnt + 1'b1;
      if (g0 || g1) rr <= g0;
      resp0_valid <= g0 && !gw;
      resp1_valid <= g1 && !gw;
      if (g0 && !gw) resp0_rdata <= rf_read_data_a;
      if (g1 && !gw) resp1_rdata <= rf_read_data_a;
    end
  end
endmodule

// File: tb/tb_register_file_arbiter.sv
// tb_register_file_arbiter: directed bench with a transaction-level model of the arbiter and a register file behind it
module tb_register_file_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
  logic [1:0] req0_index = 0, req1_index = 0;
  logic [15:0] req0_wdata = 0, req1_wdata = 0;
  logic req0_ready, req1_ready, resp0_valid, resp1_valid, rf_write_enable;
  logic [15:0] resp0_rdata, resp1_rdata, rf_read_data_a, rf_write_data;
  logic [1:0] rf_read_index_a, rf_write_index;
  logic [15:0] rf_mem [4];
  bit mem_init = 0;
  int n_cmp = 0, n_fail = 0;
  int m_sw = 0;
  bit m_ptr = 0, m_known = 0;
  logic [15:0] m_regs [4];
  bit m_rv [2];
  logic [15:0] m_rd [2];
  always #5 clk = ~clk;
  register_file_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_index(req0_index), .req0_wdata(req0_wdata),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_index(req1_index), .req1_wdata(req1_wdata),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
    .rf_read_index_a(rf_read_index_a), .rf_read_data_a(rf_read_data_a),
    .rf_write_index(rf_write_index), .rf_write_data(rf_write_data),
    .rf_write_enable(rf_write_enable)
  );
  // register file behind the arbiter, powered up with garbage so the sweep matters
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4; i++) rf_mem[i] <= 16'hdead;
      mem_init <= 1'b1;
    end else if (rf_write_enable) rf_mem[rf_write_index] <= rf_write_data;
  end
  assign rf_read_data_a = rf_mem[rf_read_index_a];
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int arb(bit v0, bit v1, bit p);
    return (v0 && v1) ? int'(p) : v0 ? 0 : v1 ? 1 : -1;
  endfunction
  function automatic int grant_now();
    return (reset || m_sw < 4) ? -1 : arb(req0_valid, req1_valid, m_ptr);
  endfunction
  // model: one transaction per cycle, memory contents, pending responses
  always @(posedge clk) begin
    int g;
    bit w;
    logic [1:0] ix;
    g = grant_now();
    w = (g == 0) ? req0_write : req1_write;
    ix = (g == 0) ? req0_index : req1_index;
    m_rv[0] <= 0;
    m_rv[1] <= 0;
    if (reset) begin
      m_known <= 1;
      m_sw <= 0;
      m_ptr <= 0;
      m_rd[0] <= 0;
      m_rd[1] <= 0;
    end else if (m_sw < 4) begin
      m_regs[m_sw] <= 0;
      m_sw <= m_sw + 1;
    end else if (g >= 0) begin
      m_ptr <= (g == 0);
      if (w) m_regs[ix] <= (g == 0) ? req0_wdata : req1_wdata;
      else begin
        m_rv[g] <= 1;
        m_rd[g] <= m_regs[ix];
      end
    end
  end
  always @(negedge clk) begin
    if (m_known) begin
      int g;
      bit w, act;
      logic [1:0] ix;
      logic [15:0] wd;
      g = grant_now();
      act = g >= 0;
      w = (g == 0) ? req0_write : req1_write;
      ix = (g == 0) ? req0_index : req1_index;
      wd = (g == 0) ? req0_wdata : req1_wdata;
      chk("ready0", 32'(req0_ready), 32'(g == 0));
      chk("ready1", 32'(req1_ready), 32'(g == 1));
      chk("wen", 32'(rf_write_enable), 32'(!reset && (m_sw < 4 || (act && w))));
      chk("widx", 32'(rf_write_index), reset ? 0 : m_sw < 4 ? 32'(m_sw) : (act && w) ? 32'(ix) : 0);
      chk("wdata", 32'(rf_write_data), (act && w) ? 32'(wd) : 0);
      chk("ridx", 32'(rf_read_index_a), (act && !w) ? 32'(ix) : 0);
      chk("resp0_valid", 32'(resp0_valid), 32'(m_rv[0]));
      chk("resp1_valid", 32'(resp1_valid), 32'(m_rv[1]));
      chk("resp0_rdata", 32'(resp0_rdata), 32'(m_rd[0]));
      chk("resp1_rdata", 32'(resp1_rdata), 32'(m_rd[1]));
    end
  end
  task automatic drive(int r, bit v, bit w, logic [1:0] ix, logic [15:0] wd);
    if (r == 0) begin
      req0_valid = v; req0_write = w; req0_index = ix; req0_wdata = wd;
    end else begin
      req1_valid = v; req1_write = w; req1_index = ix; req1_wdata = wd;
    end
  endtask
  // present one transaction, wait (bounded) for ready, return #1 after the accepting edge
  task automatic issue(int r, bit w, logic [1:0] ix, logic [15:0] wd);
    int n = 0;
    drive(r, 1, w, ix, wd);
    @(negedge clk);
    while (!(r == 0 ? req0_ready : req1_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      n_cmp++;
      n_fail++;
      $display("FAIL issue_timeout: requester %0d got no ready within 20 cycles", r);
    end
    @(posedge clk);
    #1;
    drive(r, 0, 0, 0, 0);
  endtask
  initial begin
    int seq [4];
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sweep_wen", 32'(rf_write_enable), 1);
      chk("sweep_idx", 32'(rf_write_index), i);
      chk("sweep_ready0", 32'(req0_ready), 0);
    end
    @(negedge clk);
    chk("first_ready0", 32'(req0_ready), 1);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0);
    chk("swept_rd0", 32'(resp0_rdata), 0);
    for (int i = 1; i < 4; i++) begin
      issue(1, 0, 2'(i), 0);
      chk("swept_valid", 32'(resp1_valid), 1);
      chk("swept_rd", 32'(resp1_rdata), 0);
    end
    issue(0, 1, 1, 7);
    issue(0, 0, 1, 0);
    chk("raw_valid", 32'(resp0_valid), 1);
    chk("raw_rdata", 32'(resp0_rdata), 7);
    issue(1, 0, 2, 0);
    drive(0, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seq[i] = req1_ready ? 1 : 0;
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) chk("alternate", 32'(seq[i]), 32'(i % 2));
    chk("alt_last_rdata", 32'(resp1_rdata), 7);
    issue(0, 0, 0, 0);
    drive(1, 1, 1, 2, 10);
    drive(0, 1, 0, 2, 0);
    @(negedge clk);
    chk("t4_ready1", 32'(req1_ready), 1);
    chk("t4_ready0", 32'(req0_ready), 0);
    @(posedge clk);
    #1;
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("t4_ready0_next", 32'(req0_ready), 1);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0);
    chk("t4_rdata", 32'(resp0_rdata), 10);
    issue(0, 1, 3, 5);
    issue(1, 0, 1, 0);
    chk("t5_pending", 32'(resp1_valid), 1);
    reset = 1;
    drive(1, 1, 0, 3, 0);
    @(negedge clk);
    chk("t5_ready_in_reset", 32'(req1_ready), 0);
    @(posedge clk);
    #1;
    reset = 0;
    chk("t5_dropped", 32'(resp1_valid), 0);
    issue(1, 0, 3, 0);
    chk("t5_rdata", 32'(resp1_rdata), 0);
    for (int i = 0; i < 4; i++) issue(1, 1, 2'(i), 16'(11 * (i + 1)));
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 2'(i), 0);
      @(negedge clk);
      chk("t6_ready", 32'(req1_ready), 1);
      @(posedge clk);
      #1;
      chk("t6_valid", 32'(resp1_valid), 1);
      chk("t6_rdata", 32'(resp1_rdata), 32'(11 * (i + 1)));
    end
    drive(1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
